sd_emmc_clock_monitor: RTL and testbench



---
 rtl/sd_emmc_clk_pkg.sv | 24 ++
 rtl/sd_emmc_edge_detect.sv | 38 +++
 rtl/sd_emmc_clock_monitor.sv | 163 ++++++++++++++++
 tb/tb_sd_emmc_clock_monitor.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sd_emmc_clk_pkg.sv
// rtl/sd_emmc_clk_pkg.sv - shared constants, state enum and expected half-period helper for the SD clock monitor
package sd_emmc_clk_pkg;

  localparam logic [7:0]  SDCLK_DIV_SPECIAL      = 8'h7D;
  localparam logic [11:0] SDCLK_DIV_SPECIAL_HALF = 12'd500;

  localparam logic [1:0] FAULT_NONE   = 2'b00;
  localparam logic [1:0] FAULT_PERIOD = 2'b01;
  localparam logic [1:0] FAULT_STALL  = 2'b10;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACQUIRE = 2'd1,
    LOCKED  = 2'd2,
    FAULT   = 2'd3
  } mon_state_e;

  // The special divisor code selects the 400 kHz identification-mode clock.
  function automatic logic [11:0] expected_half(input logic [7:0] div);
    if (div == SDCLK_DIV_SPECIAL) return SDCLK_DIV_SPECIAL_HALF;
    return {4'd0, div} + 12'd1;
  endfunction

endpackage

// File: rtl/sd_emmc_edge_detect.sv
// rtl/sd_emmc_edge_detect.sv - sd_clk sampler and edge pulse; SD_CLK_MON_SYNC_EN adds a 2-flop synchronizer
module sd_emmc_edge_detect (
  input  logic AXI_CLOCK,
  input  logic AXI_RST,
  input  logic sd_clk_in,
  output logic edge_pulse
);

  logic sd_s;
  logic s_q;
  logic s_qq;

`ifdef SD_CLK_MON_SYNC_EN
  logic [1:0] sync_q;

  always_ff @(posedge AXI_CLOCK or negedge AXI_RST) begin
    if (!AXI_RST) sync_q <= 2'b00;
    else          sync_q <= {sync_q[0], sd_clk_in};
  end

  assign sd_s = sync_q[1];
`else
  assign sd_s = sd_clk_in;
`endif

  always_ff @(posedge AXI_CLOCK or negedge AXI_RST) begin
    if (!AXI_RST) begin
      s_q  <= 1'b0;
      s_qq <= 1'b0;
    end else begin
      s_q  <= sd_s;
      s_qq <= s_q;
    end
  end

  assign edge_pulse = s_q ^ s_qq;

endmodule

// File: rtl/sd_emmc_clock_monitor.sv
// rtl/sd_emmc_clock_monitor.sv - SD/eMMC card clock half-period checker (lock, period error, stall); option SD_CLK_MON_SYNC_EN
module sd_emmc_clock_monitor
  import sd_emmc_clk_pkg::*;
#(
  parameter int LOCK_COUNT  = 4,
  parameter int TOL         = 1,
  parameter int STALL_EXTRA = 2
) (
  input  logic        AXI_CLOCK,
  input  logic        AXI_RST,
  input  logic        mon_en,
  input  logic        sd_clk_in,
  input  logic [7:0]  DIVISOR,
  input  logic        fault_clr,
  output logic        clk_locked,
  output logic        clk_fault,
  output logic [1:0]  fault_code,
  output logic        fault_pulse,
  output logic [11:0] meas_half_period
);

  logic        edge_pulse;
  mon_state_e  state, state_d;
  logic [11:0] cnt, cnt_d;
  logic [11:0] meas_q, meas_d;
  logic [7:0]  div_q;
  logic [3:0]  match_cnt, match_d, match_inc;
  logic        armed, armed_d;
  logic [1:0]  code_q, code_d;
  logic        pulse_q, pulse_d;
  logic        restart, fault_hit;
  logic [1:0]  fault_type;

  logic [11:0] exp_half;
  logic [11:0] diff;
  logic        in_tol;
  logic [12:0] stall_lim;
  logic        stall_hit;
  logic        div_chg;

  sd_emmc_edge_detect u_edge (
    .AXI_CLOCK  (AXI_CLOCK),
    .AXI_RST    (AXI_RST),
    .sd_clk_in  (sd_clk_in),
    .edge_pulse (edge_pulse)
  );

  assign exp_half  = expected_half(div_q);
  assign diff      = (cnt >= exp_half) ? (cnt - exp_half) : (exp_half - cnt);
  assign in_tol    = (diff <= 12'(TOL));
  assign stall_lim = {exp_half, 1'b0} + 13'(STALL_EXTRA);
  assign stall_hit = ({1'b0, cnt} >= stall_lim);
  assign div_chg   = (DIVISOR != div_q);
  assign match_inc = match_cnt + 4'd1;

  always_comb begin
    state_d    = state;
    cnt_d      = (cnt == 12'hFFF) ? cnt : cnt + 12'd1;
    meas_d     = meas_q;
    match_d    = match_cnt;
    armed_d    = armed;
    code_d     = code_q;
    pulse_d    = 1'b0;
    restart    = 1'b0;
    fault_hit  = 1'b0;
    fault_type = FAULT_NONE;
    if (edge_pulse) cnt_d = 12'd1;

    case (state)
      IDLE: begin
        cnt_d = 12'd0;
        if (mon_en) restart = 1'b1;
      end
      ACQUIRE, LOCKED: begin
        if (div_chg) begin
          restart = 1'b1;
        end else if (edge_pulse) begin
          meas_d = cnt;
          // The first edge after (re)start only opens the measurement window.
          if (state == ACQUIRE && !armed) begin
            armed_d = 1'b1;
          end else if (in_tol) begin
            if (state == ACQUIRE) begin
              match_d = match_inc;
              if (match_inc == 4'(LOCK_COUNT)) state_d = LOCKED;
            end
          end else if (state == ACQUIRE) begin
            match_d = 4'd0;
          end else begin
            fault_hit  = 1'b1;
            fault_type = FAULT_PERIOD;
          end
        end else if ((state == LOCKED || armed) && stall_hit) begin
          fault_hit  = 1'b1;
          fault_type = FAULT_STALL;
        end

        if (fault_hit) begin
          if (fault_clr) begin
            restart = 1'b1;
          end else begin
            state_d = FAULT;
            code_d  = fault_type;
            pulse_d = 1'b1;
          end
        end
      end
      FAULT: begin
        if (fault_clr) begin
          restart = 1'b1;
          code_d  = FAULT_NONE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (restart) begin
      state_d = ACQUIRE;
      cnt_d   = 12'd0;
      match_d = 4'd0;
      armed_d = 1'b0;
    end

    if (!mon_en) begin
      state_d = IDLE;
      cnt_d   = 12'd0;
      meas_d  = 12'd0;
      match_d = 4'd0;
      armed_d = 1'b0;
      code_d  = FAULT_NONE;
      pulse_d = 1'b0;
    end
  end

  always_ff @(posedge AXI_CLOCK or negedge AXI_RST) begin
    if (!AXI_RST) begin
      state     <= IDLE;
      cnt       <= 12'd0;
      meas_q    <= 12'd0;
      div_q     <= 8'd0;
      match_cnt <= 4'd0;
      armed     <= 1'b0;
      code_q    <= FAULT_NONE;
      pulse_q   <= 1'b0;
    end else begin
      state     <= state_d;
      cnt       <= cnt_d;
      meas_q    <= meas_d;
      div_q     <= DIVISOR;
      match_cnt <= match_d;
      armed     <= armed_d;
      code_q    <= code_d;
      pulse_q   <= pulse_d;
    end
  end

  assign clk_locked       = (state == LOCKED);
  assign clk_fault        = (state == FAULT);
  assign fault_code       = code_q;
  assign fault_pulse      = pulse_q;
  assign meas_half_period = meas_q;

endmodule

// File: tb/tb_sd_emmc_clock_monitor.sv
// tb/tb_sd_emmc_clock_monitor.sv - self-checking bench for sd_emmc_clock_monitor (honours SD_CLK_MON_SYNC_EN)
module tb_sd_emmc_clock_monitor;

  localparam int LOCK_COUNT  = 4;
  localparam int TOL         = 1;
  localparam int STALL_EXTRA = 2;
`ifdef SD_CLK_MON_SYNC_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 1;
`endif
  localparam int S_IDLE = 0, S_ACQ = 1, S_LCK = 2, S_FLT = 3;

  logic        AXI_CLOCK = 1'b0;
  logic        AXI_RST   = 1'b0;
  logic        mon_en    = 1'b0;
  logic        sd_clk_in = 1'b0;
  logic [7:0]  DIVISOR   = 8'd0;
  logic        fault_clr = 1'b0;
  logic        clk_locked, clk_fault, fault_pulse;
  logic [1:0]  fault_code;
  logic [11:0] meas_half_period;

  sd_emmc_clock_monitor #(
    .LOCK_COUNT(LOCK_COUNT), .TOL(TOL), .STALL_EXTRA(STALL_EXTRA)
  ) dut (
    .AXI_CLOCK        (AXI_CLOCK),
    .AXI_RST          (AXI_RST),
    .mon_en           (mon_en),
    .sd_clk_in        (sd_clk_in),
    .DIVISOR          (DIVISOR),
    .fault_clr        (fault_clr),
    .clk_locked       (clk_locked),
    .clk_fault        (clk_fault),
    .fault_code       (fault_code),
    .fault_pulse      (fault_pulse),
    .meas_half_period (meas_half_period)
  );

  always #5 AXI_CLOCK = ~AXI_CLOCK;

  int    tests = 0, fails = 0;
  int    pulse_seen = 0;
  int    ph = 0;
  string phase = "reset";

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, want, $time);
    end
  endtask

  // Reference model: timestamps of edges rather than a counter.
  int  cyc, t_ref, good, m_st, m_code, m_meas, m_divq;
  bit  armed, m_pulse;
  bit  sh [0:4];

  function automatic int m_exp(input int d);
    return (d == 125) ? 500 : d + 1;
  endfunction

  task automatic model_reset();
    cyc = 0; t_ref = 0; good = 0; m_st = S_IDLE; m_code = 0; m_meas = 0;
    m_divq = 0; armed = 0; m_pulse = 0;
    for (int k = 0; k < 5; k++) sh[k] = 0;
  endtask

  task automatic model_step();
    bit e, flt, rs;
    int el, ex, ftype, dev;
    e  = (sh[LAT-1] != sh[LAT]);
    el = cyc - t_ref;
    if (el > 4095) el = 4095;
    ex = m_exp(m_divq);
    rs = 0; flt = 0; ftype = 0;
    m_pulse = 0;
    if (!mon_en) begin
      m_st = S_IDLE; m_code = 0; m_meas = 0; t_ref = cyc + 1; armed = 0; good = 0;
    end else begin
      case (m_st)
        S_IDLE: rs = 1;
        S_ACQ, S_LCK: begin
          if (int'(DIVISOR) != m_divq) rs = 1;
          else if (e) begin
            m_meas = el; t_ref = cyc;
            dev = (el > ex) ? el - ex : ex - el;
            if (m_st == S_ACQ && !armed) armed = 1;
            else if (dev <= TOL) begin
              if (m_st == S_ACQ) begin
                good++;
                if (good == LOCK_COUNT) m_st = S_LCK;
              end
            end else if (m_st == S_ACQ) good = 0;
            else begin flt = 1; ftype = 1; end
          end else if ((m_st == S_LCK || armed) && el >= 2 * ex + STALL_EXTRA) begin
            flt = 1; ftype = 2;
          end
          if (flt) begin
            if (fault_clr) rs = 1;
            else begin m_st = S_FLT; m_code = ftype; m_pulse = 1; end
          end
        end
        default: begin
          if (e) t_ref = cyc;
          if (fault_clr) begin rs = 1; m_code = 0; end
        end
      endcase
      if (rs) begin m_st = S_ACQ; t_ref = cyc + 1; armed = 0; good = 0; end
    end
    m_divq = int'(DIVISOR);
    for (int k = 4; k > 0; k--) sh[k] = sh[k-1];
    sh[0] = sd_clk_in;
    cyc++;
  endtask

  always @(posedge AXI_CLOCK) begin
    if (!AXI_RST) model_reset();
    else          model_step();
  end

  always @(negedge AXI_CLOCK) begin
    logic [16:0] got, want;
    got  = {clk_locked, clk_fault, fault_code, fault_pulse, meas_half_period};
    want = {(m_st == S_LCK), (m_st == S_FLT), 2'(m_code), m_pulse, 12'(m_meas)};
    check({"model/", phase}, 32'(got), 32'(want));
    if (fault_pulse) pulse_seen++;
  end

  task automatic cyc_step();
    @(posedge AXI_CLOCK);
    #1;
  endtask

  task automatic toggle_run(input int per, input int n);
    for (int i = 0; i < n; i++) begin
      cyc_step();
      ph++;
      if (ph >= per) begin ph = 0; sd_clk_in = ~sd_clk_in; end
    end
  endtask

  task automatic lock_at(input logic [7:0] div, input int per, input int n);
    mon_en = 1'b0; DIVISOR = div;
    cyc_step(); cyc_step();
    mon_en = 1'b1; ph = 0;
    toggle_run(per, n);
  endtask

  typedef struct {
    logic [7:0]  div;
    int          per;
    int          ncyc;
    logic        locked;
    logic [11:0] meas;
  } vec_t;
  vec_t vecs [9];

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int k, per, r;
    model_reset();
    vecs[0] = '{8'd4,   5,   100,  1'b1, 12'd5};
    vecs[1] = '{8'h7D,  500, 3300, 1'b1, 12'd500};
    vecs[2] = '{8'd4,   6,   100,  1'b1, 12'd6};
    vecs[3] = '{8'd4,   7,   100,  1'b0, 12'd7};
    vecs[4] = '{8'd9,   10,  200,  1'b1, 12'd10};
    vecs[5] = '{8'd0,   1,   60,   1'b1, 12'd1};
    vecs[6] = '{8'd4,   3,   100,  1'b0, 12'd3};
    vecs[7] = '{8'h7C,  125, 1000, 1'b1, 12'd125};
    vecs[8] = '{8'd4,   4,   100,  1'b1, 12'd4};

    cyc_step(); cyc_step(); cyc_step();
    check("reset_outputs", 32'({clk_locked, clk_fault, fault_code, fault_pulse, meas_half_period}), 32'd0);
    AXI_RST = 1'b1;

    phase = "table";
    for (int i = 0; i < 9; i++) begin
      lock_at(vecs[i].div, vecs[i].per, vecs[i].ncyc);
      check($sformatf("vec%0d", i),
            32'({clk_locked, clk_fault, fault_code, meas_half_period}),
            32'({vecs[i].locked, 1'b0, 2'b00, vecs[i].meas}));
    end

    phase = "special_period_err";
    lock_at(8'h7D, 500, 3300);
    check("spec_locked", 32'({clk_locked, meas_half_period}), 32'({1'b1, 12'd500}));
    pulse_seen = 0;
    toggle_run(502, 600);
    check("spec_fault", 32'({clk_locked, clk_fault, fault_code}), 32'({1'b0, 1'b1, 2'b01}));
    check("spec_pulses", 32'(pulse_seen), 32'd1);

    phase = "stall";
    lock_at(8'd4, 5, 80);
    check("stall_prelock", 32'(clk_locked), 32'd1);
    toggle_run(5, 5 - ph);
    pulse_seen = 0;
    k = 0;
    while (!clk_fault && k < 100) begin cyc_step(); k++; end
    check("stall_latency", 32'(k), 32'(13 + LAT));
    check("stall_code", 32'({clk_locked, fault_code}), 32'({1'b0, 2'b10}));
    cyc_step(); cyc_step();
    check("stall_pulses", 32'(pulse_seen), 32'd1);
    fault_clr = 1'b1; cyc_step(); fault_clr = 1'b0;
    check("stall_clr", 32'({clk_fault, fault_code}), 32'd0);
    ph = 0;
    toggle_run(5, 80);
    check("stall_relock", 32'({clk_locked, clk_fault}), 32'({1'b1, 1'b0}));

    phase = "div_change";
    lock_at(8'd4, 5, 80);
    DIVISOR = 8'd9; cyc_step();
    check("divchg_unlock", 32'({clk_locked, clk_fault}), 32'd0);
    toggle_run(10, 150);
    check("divchg_relock", 32'({clk_locked, clk_fault, meas_half_period}), 32'({1'b1, 1'b0, 12'd10}));

    phase = "tolerance";
    lock_at(8'd4, 5, 80);
    toggle_run(6, 60);
    check("tol_stays_locked", 32'({clk_locked, clk_fault, meas_half_period}), 32'({1'b1, 1'b0, 12'd6}));

    phase = "clr_vs_mismatch";
    lock_at(8'd4, 5, 80);
    toggle_run(5, 5 - ph);
    pulse_seen = 0;
    repeat (7) cyc_step();
    sd_clk_in = ~sd_clk_in;
    repeat (LAT) cyc_step();
    fault_clr = 1'b1; cyc_step(); fault_clr = 1'b0;
    check("clr_wins", 32'({clk_locked, clk_fault, fault_code}), 32'd0);
    check("clr_no_pulse", 32'(pulse_seen), 32'd0);
    ph = 0;

    phase = "mon_en_drop";
    lock_at(8'd4, 5, 80);
    toggle_run(5, 3);
    mon_en = 1'b0; cyc_step();
    check("mon_en_clear", 32'({clk_locked, clk_fault, fault_code, fault_pulse, meas_half_period}), 32'd0);
    mon_en = 1'b1;

    phase = "reset_mid";
    lock_at(8'd4, 5, 80);
    toggle_run(5, 2);
    pulse_seen = 0;
    #3;
    AXI_RST = 1'b0;
    model_reset();
    #1;
    check("reset_mid_clear", 32'({clk_locked, clk_fault, fault_code, fault_pulse, meas_half_period}), 32'd0);
    cyc_step(); cyc_step();
    AXI_RST = 1'b1;
    cyc_step();
    check("reset_no_pulse", 32'(pulse_seen), 32'd0);

    phase = "random";
    lock_at(8'd4, 5, 40);
    per = 5;
    for (int i = 0; i < 4000; i++) begin
      cyc_step();
      fault_clr = ($urandom_range(0, 39) == 0);
      mon_en    = ($urandom_range(0, 999) != 0);
      if ($urandom_range(0, 599) == 0) DIVISOR = 8'($urandom_range(0, 20));
      ph++;
      if (ph >= per) begin
        ph = 0;
        sd_clk_in = ~sd_clk_in;
        r = int'($urandom_range(0, 49));
        if (r == 0) per = 2 * m_exp(int'(DIVISOR)) + 4;
        else        per = m_exp(int'(DIVISOR)) + int'($urandom_range(0, 4)) - 2;
        if (per < 1) per = 1;
      end
    end
    fault_clr = 1'b0;
    cyc_step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
